// File: rtl/clock_time_controller.sv
// Timekeeping sequencer for the digital clock.
// Advances a BCD hh:mm:ss time-of-day on a 1 Hz tick enable and runs the
// RUN / SET_HR / SET_MIN mode machine driven by two push-buttons.
module clock_time_controller #(
    parameter int RESET_HOUR  = 0,
    parameter int RESET_MIN   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [1:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] mode,
    output logic       blink,
    output logic       day_wrap
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        BAD     = 2'b11
    } mode_t;

    // Reset time split into BCD digits at elaboration time
    localparam logic [1:0] RST_HR_T  = 2'(RESET_HOUR / 10);
    localparam logic [3:0] RST_HR_O  = 4'(RESET_HOUR % 10);
    localparam logic [2:0] RST_MIN_T = 3'(RESET_MIN / 10);
    localparam logic [3:0] RST_MIN_O = 4'(RESET_MIN % 10);

    mode_t                  state;
    logic [SYNC_STAGES-1:0] mode_sync;
    logic [SYNC_STAGES-1:0] inc_sync;
    logic                   mode_prev;
    logic                   inc_prev;
    logic                   mode_p;
    logic                   inc_p;

    // BCD hour increment, 23 wraps to 00
    function automatic logic [5:0] hour_inc(input logic [1:0] t, input logic [3:0] o);
        if (t == 2'd2 && o == 4'd3)
            return 6'd0;
        else if (o == 4'd9)
            return {t + 2'd1, 4'd0};
        else
            return {t, o + 4'd1};
    endfunction

    // BCD minute increment, 59 wraps to 00 (caller decides on hour carry)
    function automatic logic [6:0] min_inc(input logic [2:0] t, input logic [3:0] o);
        if (o == 4'd9) begin
            if (t == 3'd5)
                return 7'd0;
            else
                return {t + 3'd1, 4'd0};
        end else begin
            return {t, o + 4'd1};
        end
    endfunction

    // Button synchronizers plus the previous-value flops for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_sync <= '0;
            inc_sync  <= '0;
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
        end else begin
            mode_sync <= {mode_sync[SYNC_STAGES-2:0], btn_mode};
            inc_sync  <= {inc_sync[SYNC_STAGES-2:0], btn_inc};
            mode_prev <= mode_sync[SYNC_STAGES-1];
            inc_prev  <= inc_sync[SYNC_STAGES-1];
        end
    end

    // One-cycle pulses on the synchronized rising edges; a held button gives one pulse
    always_comb begin
        mode_p = mode_sync[SYNC_STAGES-1] & ~mode_prev;
        inc_p  = inc_sync[SYNC_STAGES-1] & ~inc_prev;
    end

    assign mode = state;

    // Mode machine and time registers; mode_p has priority over tick and inc_p
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            hr_tens  <= RST_HR_T;
            hr_ones  <= RST_HR_O;
            min_tens <= RST_MIN_T;
            min_ones <= RST_MIN_O;
            sec_tens <= 3'd0;
            sec_ones <= 4'd0;
            blink    <= 1'b0;
            day_wrap <= 1'b0;
        end else begin
            day_wrap <= 1'b0;
            case (state)
                RUN: begin
                    blink <= 1'b0;
                    if (mode_p) begin
                        state    <= SET_HR;
                        sec_tens <= 3'd0;
                        sec_ones <= 4'd0;
                        blink    <= 1'b1;
                    end else if (tick) begin
                        // Full carry chain resolves within this one edge
                        if (sec_ones != 4'd9) begin
                            sec_ones <= sec_ones + 4'd1;
                        end else begin
                            sec_ones <= 4'd0;
                            if (sec_tens != 3'd5) begin
                                sec_tens <= sec_tens + 3'd1;
                            end else begin
                                sec_tens <= 3'd0;
                                {min_tens, min_ones} <= min_inc(min_tens, min_ones);
                                if (min_tens == 3'd5 && min_ones == 4'd9) begin
                                    {hr_tens, hr_ones} <= hour_inc(hr_tens, hr_ones);
                                    if (hr_tens == 2'd2 && hr_ones == 4'd3)
                                        day_wrap <= 1'b1;
                                end
                            end
                        end
                    end
                end
                SET_HR: begin
                    if (mode_p) begin
                        state <= SET_MIN;
                        blink <= 1'b1;
                    end else begin
                        if (tick)
                            blink <= ~blink;
                        if (inc_p)
                            {hr_tens, hr_ones} <= hour_inc(hr_tens, hr_ones);
                    end
                end
                SET_MIN: begin
                    if (mode_p) begin
                        state <= RUN;
                        blink <= 1'b0;
                    end else begin
                        if (tick)
                            blink <= ~blink;
                        if (inc_p)
                            {min_tens, min_ones} <= min_inc(min_tens, min_ones);
                    end
                end
                default: begin
                    state <= RUN;
                    blink <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_time_controller.sv
// Testbench for clock_time_controller: directed set/carry/collision steps
// followed by random tick and button activity, all against a time-of-day model.
module tb_clock_time_controller;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;

    logic [1:0] hr_tens, hr_tens2;
    logic [3:0] hr_ones, hr_ones2;
    logic [2:0] min_tens, min_tens2;
    logic [3:0] min_ones, min_ones2;
    logic [2:0] sec_tens, sec_tens2;
    logic [3:0] sec_ones, sec_ones2;
    logic [1:0] mode, mode2;
    logic       blink, blink2;
    logic       day_wrap, day_wrap2;

    logic [23:0] dut_v, dut2_v;
    assign dut_v  = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones, mode, blink, day_wrap};
    assign dut2_v = {hr_tens2, hr_ones2, min_tens2, min_ones2, sec_tens2, sec_ones2, mode2, blink2, day_wrap2};

    clock_time_controller #(.RESET_HOUR(0), .RESET_MIN(0), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones), .mode(mode), .blink(blink), .day_wrap(day_wrap)
    );

    clock_time_controller #(.RESET_HOUR(12), .RESET_MIN(30), .SYNC_STAGES(SYNC)) dut2 (
        .clk(clk), .reset(reset), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hr_tens(hr_tens2), .hr_ones(hr_ones2), .min_tens(min_tens2), .min_ones(min_ones2),
        .sec_tens(sec_tens2), .sec_ones(sec_ones2), .mode(mode2), .blink(blink2), .day_wrap(day_wrap2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // Reference model: plain integer time of day, mode number, blink, wrap flag
    int mh = 0, mmin = 0, msec = 0, mmode = 0;
    bit mbl = 1'b0, mdw = 1'b0;
    bit hm[SYNC+2];
    bit hi[SYNC+2];

    function automatic logic [23:0] pack(int h, int m, int s, int md, bit bl, bit dw);
        logic [1:0] ht;
        logic [3:0] ho;
        logic [2:0] mt;
        logic [3:0] mo;
        logic [2:0] st;
        logic [3:0] so;
        logic [1:0] mdv;
        ht = 2'(h / 10);
        ho = 4'(h % 10);
        mt = 3'(m / 10);
        mo = 4'(m % 10);
        st = 3'(s / 10);
        so = 4'(s % 10);
        mdv = 2'(md);
        return {ht, ho, mt, mo, st, so, mdv, bl, dw};
    endfunction

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mh = 0; mmin = 0; msec = 0; mmode = 0; mbl = 1'b0; mdw = 1'b0;
        for (int i = 0; i < SYNC + 2; i++) begin
            hm[i] = 1'b0;
            hi[i] = 1'b0;
        end
    endtask

    // A button level seen at edge n acts at edge n+SYNC, once per low-to-high change
    task automatic model_step(input bit t, input bit bm, input bit bi);
        bit mp, ip;
        int tot;
        for (int i = SYNC + 1; i > 0; i--) begin
            hm[i] = hm[i-1];
            hi[i] = hi[i-1];
        end
        hm[0] = bm;
        hi[0] = bi;
        mp = hm[SYNC] & ~hm[SYNC+1];
        ip = hi[SYNC] & ~hi[SYNC+1];
        mdw = 1'b0;
        case (mmode)
            0: begin
                if (mp) begin
                    mmode = 1; msec = 0; mbl = 1'b1;
                end else if (t) begin
                    tot = mh * 3600 + mmin * 60 + msec + 1;
                    if (tot == 86400) begin
                        tot = 0;
                        mdw = 1'b1;
                    end
                    mh = tot / 3600;
                    mmin = (tot / 60) % 60;
                    msec = tot % 60;
                end
            end
            1: begin
                if (mp) begin
                    mmode = 2; mbl = 1'b1;
                end else begin
                    if (t) mbl = ~mbl;
                    if (ip) mh = (mh + 1) % 24;
                end
            end
            default: begin
                if (mp) begin
                    mmode = 0; mbl = 1'b0;
                end else begin
                    if (t) mbl = ~mbl;
                    if (ip) mmin = (mmin + 1) % 60;
                end
            end
        endcase
    endtask

    // One clock: drive at the falling edge, model the rising edge, compare just after it
    task automatic cyc(input bit t, input bit bm, input bit bi);
        tick = t;
        btn_mode = bm;
        btn_inc = bi;
        @(posedge clk);
        model_step(t, bm, bi);
        #1;
        chk("cycle", dut_v, pack(mh, mmin, msec, mmode, mbl, mdw));
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic press_mode();
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_inc(input int n);
        repeat (n) begin
            cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        bit rbm, rbi, rt;
        model_reset();

        // Power-on reset values
        @(negedge clk);
        chk("reset_default", dut_v, pack(0, 0, 0, 0, 1'b0, 1'b0));
        chk("reset_param", dut2_v, pack(12, 30, 0, 0, 1'b0, 1'b0));
        reset = 1'b0;

        ticks(5);
        chk("five_ticks", dut_v, pack(0, 0, 5, 0, 1'b0, 1'b0));

        // Load 12:34 and run to 12:34:27
        press_mode();
        press_inc(12);
        press_mode();
        press_inc(34);
        press_mode();
        ticks(27);
        chk("run_12_34_27", dut_v, pack(12, 34, 27, 0, 1'b0, 1'b0));

        // Set flow with hour and minute wraps
        press_mode();
        chk("enter_set_hr", dut_v, pack(12, 34, 0, 1, 1'b1, 1'b0));
        press_inc(12);
        chk("hour_wrap", dut_v, pack(0, 34, 0, 1, 1'b1, 1'b0));
        press_mode();
        chk("enter_set_min", dut_v, pack(0, 34, 0, 2, 1'b1, 1'b0));
        press_inc(26);
        chk("min_wrap_no_carry", dut_v, pack(0, 0, 0, 2, 1'b1, 1'b0));
        press_mode();
        chk("back_to_run", dut_v, pack(0, 0, 0, 0, 1'b0, 1'b0));
        ticks(1);
        chk("resume_tick", dut_v, pack(0, 0, 1, 0, 1'b0, 1'b0));

        // Minute-to-hour carry from 00:59:59
        press_mode();
        press_mode();
        press_inc(59);
        press_mode();
        ticks(59);
        chk("at_00_59_59", dut_v, pack(0, 59, 59, 0, 1'b0, 1'b0));
        ticks(1);
        chk("carry_to_hour", dut_v, pack(1, 0, 0, 0, 1'b0, 1'b0));

        // Day rollover from 23:59:59
        press_mode();
        press_inc(22);
        press_mode();
        press_inc(59);
        press_mode();
        ticks(59);
        chk("at_23_59_59", dut_v, pack(23, 59, 59, 0, 1'b0, 1'b0));
        ticks(1);
        chk("day_wrap_pulse", dut_v, pack(0, 0, 0, 0, 1'b0, 1'b1));
        cyc(1'b0, 1'b0, 1'b0);
        chk("day_wrap_clear", dut_v, pack(0, 0, 0, 0, 1'b0, 1'b0));

        // Ticks only toggle blink in SET_HR
        press_mode();
        chk("blink_0", dut_v, pack(0, 0, 0, 1, 1'b1, 1'b0));
        ticks(1);
        chk("blink_1", dut_v, pack(0, 0, 0, 1, 1'b0, 1'b0));
        ticks(1);
        chk("blink_2", dut_v, pack(0, 0, 0, 1, 1'b1, 1'b0));
        ticks(1);
        chk("blink_3", dut_v, pack(0, 0, 0, 1, 1'b0, 1'b0));
        press_mode();
        press_mode();
        ticks(3);
        chk("run_blink_low", dut_v, pack(0, 0, 3, 0, 1'b0, 1'b0));

        // mode_p coinciding with tick in RUN: tick is dropped
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("mode_beats_tick", dut_v, pack(0, 0, 0, 1, 1'b1, 1'b0));
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        press_inc(7);

        // mode_p coinciding with inc_p in SET_HR: inc is dropped
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("mode_beats_inc", dut_v, pack(7, 0, 0, 2, 1'b1, 1'b0));
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        press_inc(44);

        // Held increment button counts once
        repeat (100) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("held_inc_once", dut_v, pack(7, 45, 0, 2, 1'b1, 1'b0));

        // Asynchronous reset in SET_MIN at 07:45, no clock edge needed
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", dut_v, pack(0, 0, 0, 0, 1'b0, 1'b0));
        chk("async_reset_param", dut2_v, pack(12, 30, 0, 0, 1'b0, 1'b0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Random ticks and button activity
        rbm = 1'b0;
        rbi = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(7) == 0) rbm = ~rbm;
            if ($urandom_range(3) == 0) rbi = ~rbi;
            rt = ($urandom_range(2) == 0);
            cyc(rt, rbm, rbi);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
